tick_sched: RTL

Programmable clock-enable scheduler driving the pixel/logic tick domain. It generates a one-cycle `tick` strobe every N system clocks and a square `div_clk` that toggles on each tick. It accepts run/stop control and divisor reconfiguration through a valid/ready handshake. New divisors take effect only on period boundaries, so downstream consumers never see a truncated period. With N=1 it reproduces the legacy mod-2 divider: 25 MHz from 50 MHz.

---
 rtl/tick_sched.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/tick_sched.sv
// rtl/tick_sched.sv - programmable tick / divided-clock scheduler with boundary-aligned divisor updates
//
// Generates a one-cycle tick every cur_div clocks and a square div_clk that
// toggles on each tick. Divisor changes while running are held in a pending
// register and applied only at a period wrap, so no period is ever truncated.
//
// Ports:
//   clk       - system clock, rising edge
//   reset     - synchronous active-low reset
//   en        - run request (level)
//   cfg_valid - divisor update request
//   cfg_div   - requested divisor
//   cfg_ready - divisor can be accepted this cycle (low while one is pending)
//   cfg_err   - one-cycle pulse after a zero divisor is accepted
//   tick      - one-cycle strobe at each period wrap
//   div_clk   - square wave, period 2*cur_div
//   running   - block is not idle
//   cur_div   - divisor currently in effect
module tick_sched #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             tick,
    output logic             div_clk,
    output logic             running,
    output logic [WIDTH-1:0] cur_div
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] pend, pend_n;
    logic [WIDTH-1:0] cur_div_n;
    logic             tick_n;
    logic             div_clk_n;
    logic             cfg_err_n;

    logic             hs;
    logic             hs_nz;
    logic             wrap;

    assign cfg_ready = (state != PEND);
    assign running   = (state != IDLE);
    assign hs        = cfg_valid & cfg_ready;
    assign hs_nz     = hs & (cfg_div != '0);
    // cur_div is never zero, so the subtraction cannot underflow.
    assign wrap      = (cnt == cur_div - WIDTH'(1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pend    <= '0;
            cur_div <= WIDTH'(DEFAULT_DIV);
            tick    <= 1'b0;
            div_clk <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            pend    <= pend_n;
            cur_div <= cur_div_n;
            tick    <= tick_n;
            div_clk <= div_clk_n;
            cfg_err <= cfg_err_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        pend_n    = pend;
        cur_div_n = cur_div;
        tick_n    = 1'b0;
        div_clk_n = div_clk;
        // A zero divisor is still a completed handshake; it only flags an error.
        cfg_err_n = hs & (cfg_div == '0);

        case (state)
            IDLE: begin
                cnt_n     = '0;
                div_clk_n = 1'b0;
                // Written before the first period, so a same-edge en rise uses it.
                if (hs_nz) begin
                    cur_div_n = cfg_div;
                end
                if (en) begin
                    state_n = RUN;
                end
            end

            RUN, PEND: begin
                if (!en) begin
                    // Stop wins over a same-edge wrap: no tick, outputs forced low.
                    state_n   = IDLE;
                    cnt_n     = '0;
                    div_clk_n = 1'b0;
                    if (state == PEND) begin
                        cur_div_n = pend;
                    end else if (hs_nz) begin
                        cur_div_n = cfg_div;
                    end
                end else begin
                    if (wrap) begin
                        cnt_n     = '0;
                        tick_n    = 1'b1;
                        div_clk_n = ~div_clk;
                        if (state == PEND) begin
                            cur_div_n = pend;
                            state_n   = RUN;
                        end
                    end else begin
                        cnt_n = cnt + WIDTH'(1);
                    end
                    // Only reachable in RUN since cfg_ready is low in PEND.
                    if (hs_nz) begin
                        pend_n  = cfg_div;
                        state_n = PEND;
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
